// File: rtl/mac_lane_driver.sv
// mac_lane_driver: transmit side of the PE weight/ifmap load protocol for one
// lane of the MAC systolic array.
//   - Weights: takes DEPTH beats from an upstream valid/ready source and shifts
//     them down one array column (w_prefetch_out, w_enable_out, w_data_out).
//   - Ifmaps: streams len_i words into one array row through a SKEW-stage delay
//     line (ifmap_start_out, ifmap_enable_out, ifmap_data_out, mac_valid_out).
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   start_i, len_i                 job launch and ifmap beat count (IDLE only)
//   busy_o, done_o                 job in progress, one-cycle end-of-job pulse
//   w_data_i/w_valid_i/w_ready_o   upstream weight handshake
//   if_data_i/if_valid_i/if_ready_o upstream ifmap handshake
//   w_*_out, ifmap_*_out, mac_*_out array-edge outputs (registered)
module mac_lane_driver #(
    parameter int unsigned IFMAP_BITWIDTH = 16,
    parameter int unsigned W_BITWIDTH     = 8,
    parameter int unsigned OFMAP_BITWIDTH = 32,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned SKEW           = 0,
    parameter int unsigned LEN_W          = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start_i,
    input  logic [LEN_W-1:0]          len_i,
    output logic                      busy_o,
    output logic                      done_o,
    input  logic [W_BITWIDTH-1:0]     w_data_i,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    input  logic [IFMAP_BITWIDTH-1:0] if_data_i,
    input  logic                      if_valid_i,
    output logic                      if_ready_o,
    output logic                      w_prefetch_out,
    output logic                      w_enable_out,
    output logic [W_BITWIDTH-1:0]     w_data_out,
    output logic                      ifmap_start_out,
    output logic                      ifmap_enable_out,
    output logic [IFMAP_BITWIDTH-1:0] ifmap_data_out,
    output logic                      mac_valid_out,
    output logic [OFMAP_BITWIDTH-1:0] mac_data_out
);

    localparam int unsigned WC_W    = $clog2(DEPTH + 1);
    localparam int unsigned DRAIN_N = SKEW + DEPTH;
    localparam int unsigned DC_W    = $clog2(DRAIN_N + 1);
    localparam int unsigned SL_W    = IFMAP_BITWIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_PRE,
        S_W_LOAD,
        S_I_START,
        S_I_STREAM,
        S_DRAIN
    } state_t;

    state_t               r_state;
    logic [LEN_W-1:0]     r_len;
    logic [WC_W-1:0]      r_w_cnt;
    logic [LEN_W-1:0]     r_if_cnt;
    logic [DC_W-1:0]      r_dr_cnt;
    logic                 r_done;
    logic                 r_w_prefetch;
    logic                 r_w_enable;
    logic [W_BITWIDTH-1:0] r_w_data;
    logic                 r_if_start;
    logic                 r_if_enable;
    logic [IFMAP_BITWIDTH-1:0] r_if_data;

    logic                 w_w_fire;
    logic                 w_if_fire;
    logic [SL_W-1:0]      w_sl_in;
    logic [SL_W-1:0]      w_sl_tap;

    // Upstream readies depend on state only.
    assign w_ready_o  = (r_state == S_W_LOAD);
    assign if_ready_o = (r_state == S_I_STREAM);
    assign busy_o     = (r_state != S_IDLE);
    assign w_w_fire   = w_valid_i && w_ready_o;
    assign w_if_fire  = if_valid_i && if_ready_o;

    // Job sequencer and weight-side outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_w_cnt      <= '0;
            r_if_cnt     <= '0;
            r_dr_cnt     <= '0;
            r_done       <= 1'b0;
            r_w_prefetch <= 1'b0;
            r_w_enable   <= 1'b0;
            r_w_data     <= '0;
        end else begin
            r_done       <= 1'b0;
            r_w_prefetch <= 1'b0;
            r_w_enable   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_len    <= len_i;
                        r_w_cnt  <= '0;
                        r_if_cnt <= '0;
                        r_dr_cnt <= '0;
                        r_state  <= S_W_PRE;
                    end
                end
                S_W_PRE: begin
                    r_w_prefetch <= 1'b1;
                    r_state      <= S_W_LOAD;
                end
                S_W_LOAD: begin
                    if (w_w_fire) begin
                        r_w_enable <= 1'b1;
                        r_w_data   <= w_data_i;
                        if (r_w_cnt == WC_W'(DEPTH - 1)) begin
                            r_state <= S_I_START;
                        end else begin
                            r_w_cnt <= r_w_cnt + WC_W'(1);
                        end
                    end
                end
                S_I_START: begin
                    r_state <= (r_len == '0) ? S_DRAIN : S_I_STREAM;
                end
                S_I_STREAM: begin
                    if (w_if_fire) begin
                        if ((r_if_cnt + LEN_W'(1)) == r_len) begin
                            r_state <= S_DRAIN;
                        end
                        if (r_if_cnt != '1) begin
                            r_if_cnt <= r_if_cnt + LEN_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // Flush the skew line and the column; done lands in the
                    // first IDLE cycle.
                    if (r_dr_cnt == DC_W'(DRAIN_N - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_dr_cnt <= r_dr_cnt + DC_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Skew line input: {start, valid, data}.
    always_comb begin
        w_sl_in = '0;
        if (r_state == S_I_START) begin
            w_sl_in[SL_W-1] = 1'b1;
        end
        if (w_if_fire) begin
            w_sl_in = {1'b0, 1'b1, if_data_i};
        end
    end

    // SKEW delay stages ahead of the output register.
    generate
        if (SKEW == 0) begin : g_noskew
            assign w_sl_tap = w_sl_in;
        end else begin : g_skew
            logic [SL_W-1:0] r_sl [SKEW];
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    for (int unsigned i = 0; i < SKEW; i++) begin
                        r_sl[i] <= '0;
                    end
                end else begin
                    r_sl[0] <= w_sl_in;
                    for (int unsigned i = 1; i < SKEW; i++) begin
                        r_sl[i] <= r_sl[i-1];
                    end
                end
            end
            assign w_sl_tap = r_sl[SKEW-1];
        end
    endgenerate

    // Row-side output register; data holds across invalid cycles.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_if_start  <= 1'b0;
            r_if_enable <= 1'b0;
            r_if_data   <= '0;
        end else begin
            r_if_start  <= w_sl_tap[SL_W-1];
            r_if_enable <= w_sl_tap[SL_W-2];
            if (w_sl_tap[SL_W-2]) begin
                r_if_data <= w_sl_tap[IFMAP_BITWIDTH-1:0];
            end
        end
    end

    assign done_o           = r_done;
    assign w_prefetch_out   = r_w_prefetch;
    assign w_enable_out     = r_w_enable;
    assign w_data_out       = r_w_data;
    assign ifmap_start_out  = r_if_start;
    assign ifmap_enable_out = r_if_enable;
    assign ifmap_data_out   = r_if_data;
    assign mac_valid_out    = r_if_enable;
    assign mac_data_out     = '0;

endmodule

// File: tb/tb_mac_lane_driver.sv
// Scoreboard bench for mac_lane_driver (DEPTH=4, SKEW=3): the driver pushes
// expected output cycles/data when it issues stimulus, a negedge monitor pops
// and compares whenever the DUT presents an output.
module tb_mac_lane_driver;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SKEW  = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_i;
    logic [15:0] len_i;
    logic        busy_o, done_o;
    logic [7:0]  w_data_i;
    logic        w_valid_i, w_ready_o;
    logic [15:0] if_data_i;
    logic        if_valid_i, if_ready_o;
    logic        w_prefetch_out, w_enable_out;
    logic [7:0]  w_data_out;
    logic        ifmap_start_out, ifmap_enable_out;
    logic [15:0] ifmap_data_out;
    logic        mac_valid_out;
    logic [31:0] mac_data_out;

    mac_lane_driver #(
        .IFMAP_BITWIDTH(16), .W_BITWIDTH(8), .OFMAP_BITWIDTH(32),
        .DEPTH(DEPTH), .SKEW(SKEW), .LEN_W(16)
    ) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o),
        .w_data_i(w_data_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .if_data_i(if_data_i), .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
        .w_prefetch_out(w_prefetch_out), .w_enable_out(w_enable_out),
        .w_data_out(w_data_out), .ifmap_start_out(ifmap_start_out),
        .ifmap_enable_out(ifmap_enable_out), .ifmap_data_out(ifmap_data_out),
        .mac_valid_out(mac_valid_out), .mac_data_out(mac_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    int          q_pre[$];
    int          q_st[$];
    int          q_done[$];
    int          q_w_cyc[$];
    logic [7:0]  q_w_dat[$];
    int          q_if_cyc[$];
    logic [15:0] q_if_dat[$];

    bit          rst_prev = 1'b0;
    logic [7:0]  last_w   = '0;
    logic [15:0] last_if  = '0;

    task automatic chk_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flush_queues();
        q_pre.delete(); q_st.delete(); q_done.delete();
        q_w_cyc.delete(); q_w_dat.delete(); q_if_cyc.delete(); q_if_dat.delete();
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (!rstn) begin
            flush_queues();
            rst_prev = 1'b1;
        end else if (rst_prev) begin
            rst_prev = 1'b0;
            chk_eq("rst_busy",     busy_o, 0);
            chk_eq("rst_done",     done_o, 0);
            chk_eq("rst_prefetch", w_prefetch_out, 0);
            chk_eq("rst_w_enable", w_enable_out, 0);
            chk_eq("rst_w_data",   w_data_out, 0);
            chk_eq("rst_if_start", ifmap_start_out, 0);
            chk_eq("rst_if_en",    ifmap_enable_out, 0);
            chk_eq("rst_if_data",  ifmap_data_out, 0);
            chk_eq("rst_mac_valid", mac_valid_out, 0);
            chk_eq("rst_mac_data", mac_data_out, 0);
            last_w  = '0;
            last_if = '0;
        end else begin
            chk_eq("mac_data_zero", mac_data_out, 0);
            if (w_prefetch_out) begin
                if (q_pre.size() == 0) chk_eq("prefetch_unexpected", w_prefetch_out, 0);
                else chk_eq("prefetch_cycle", cyc, q_pre.pop_front());
            end
            if (w_enable_out) begin
                if (q_w_cyc.size() == 0) chk_eq("w_enable_unexpected", w_enable_out, 0);
                else begin
                    chk_eq("w_cycle", cyc, q_w_cyc.pop_front());
                    chk_eq("w_data",  w_data_out, q_w_dat.pop_front());
                end
                last_w = w_data_out;
            end else begin
                chk_eq("w_data_hold", w_data_out, last_w);
            end
            if (ifmap_start_out) begin
                if (q_st.size() == 0) chk_eq("if_start_unexpected", ifmap_start_out, 0);
                else chk_eq("if_start_cycle", cyc, q_st.pop_front());
            end
            chk_eq("mac_valid_eq_enable", mac_valid_out, ifmap_enable_out);
            if (ifmap_enable_out) begin
                if (q_if_cyc.size() == 0) chk_eq("if_enable_unexpected", ifmap_enable_out, 0);
                else begin
                    chk_eq("if_cycle", cyc, q_if_cyc.pop_front());
                    chk_eq("if_data",  ifmap_data_out, q_if_dat.pop_front());
                end
                last_if = ifmap_data_out;
            end else begin
                chk_eq("if_data_hold", ifmap_data_out, last_if);
            end
            if (done_o) begin
                chk_eq("busy_at_done", busy_o, 0);
                if (q_done.size() == 0) chk_eq("done_unexpected", done_o, 0);
                else chk_eq("done_cycle", cyc, q_done.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One job: launch, weights under wpat, ifmaps under ipat; optional abort
    // by reset once abort_at ifmaps have been accepted.
    task automatic run_job(input int len, input bit hold,
                           input logic [7:0] wpat, input int wplen,
                           input logic [7:0] ipat, input int iplen,
                           input int abort_at,
                           input logic [7:0] wbase, input logic [15:0] ibase);
        int n;
        int acc;
        int idx;
        int tw;
        start_i = 1'b1;
        len_i   = 16'(len);
        n = 0;
        while (busy_o && n < 200) begin step(); n++; end
        if (busy_o) begin
            chk_eq("launch_timeout", busy_o, 0);
            return;
        end
        q_pre.push_back(cyc + 2);
        step();
        if (!hold) begin
            start_i = 1'b0;
            len_i   = 16'hFFFF;
        end
        acc = 0; idx = 0; tw = 0; n = 0;
        while (acc < int'(DEPTH) && n < 200) begin
            w_valid_i = 1'b0;
            w_data_i  = 8'hEE;
            if (w_ready_o) begin
                w_valid_i = wpat[idx % wplen];
                idx++;
                if (w_valid_i) begin
                    w_data_i = wbase + 8'(acc);
                    q_w_cyc.push_back(cyc + 1);
                    q_w_dat.push_back(w_data_i);
                    acc++;
                    tw = cyc;
                end
            end
            step();
            n++;
        end
        w_valid_i = 1'b0;
        if (acc < int'(DEPTH)) begin
            chk_eq("weight_timeout", acc, DEPTH);
            return;
        end
        q_st.push_back(tw + 2 + int'(SKEW));
        if (len == 0) q_done.push_back(tw + 2 + int'(DEPTH) + int'(SKEW));
        acc = 0; idx = 0; n = 0;
        while (acc < len && n < 400) begin
            if (abort_at > 0 && acc == abort_at) begin
                rstn       = 1'b0;
                if_valid_i = 1'b0;
                start_i    = 1'b0;
                step();
                rstn = 1'b1;
                step();
                return;
            end
            if_valid_i = 1'b0;
            if_data_i  = 16'hDEAD;
            if (if_ready_o) begin
                if_valid_i = ipat[idx % iplen];
                idx++;
                if (if_valid_i) begin
                    if_data_i = 16'(ibase * 16'(acc + 1));
                    q_if_cyc.push_back(cyc + 1 + int'(SKEW));
                    q_if_dat.push_back(if_data_i);
                    acc++;
                    if (acc == len) q_done.push_back(cyc + 1 + int'(DEPTH) + int'(SKEW));
                end
            end
            step();
            n++;
        end
        if_valid_i = 1'b0;
        if (acc < len) begin
            chk_eq("ifmap_timeout", acc, len);
            return;
        end
        n = 0;
        while (busy_o && n < 200) begin step(); n++; end
        if (busy_o) chk_eq("drain_timeout", busy_o, 0);
    endtask

    initial begin
        rstn = 1'b0; start_i = 1'b0; len_i = '0;
        w_data_i = '0; w_valid_i = 1'b0; if_data_i = '0; if_valid_i = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        repeat (2) step();
        // Back-to-back weights 1..4, ifmaps 10,20,30.
        run_job(3, 1'b0, 8'b1, 1, 8'b1, 1, 0, 8'd1, 16'd10);
        repeat (2) step();
        // Weight gaps 1,0,1,1,0,1; ifmap gaps 1,0,1.
        run_job(4, 1'b0, 8'b0010_1101, 6, 8'b0000_0101, 3, 0, 8'd5, 16'h0111);
        repeat (3) step();
        // Empty ifmap stream.
        run_job(0, 1'b0, 8'b1, 1, 8'b1, 1, 0, 8'd9, 16'd1);
        repeat (2) step();
        // start_i held high across a job: second job launches in the done cycle.
        run_job(2, 1'b1, 8'b1, 1, 8'b1, 1, 0, 8'h20, 16'h0100);
        run_job(2, 1'b0, 8'b1, 1, 8'b1, 1, 0, 8'h30, 16'h0200);
        chk_eq("busy_after_second", busy_o, 0);
        repeat (2) step();
        // Reset during I_STREAM aborts; then a normal job.
        run_job(5, 1'b0, 8'b1, 1, 8'b1, 1, 2, 8'h40, 16'h0300);
        repeat (4) step();
        run_job(2, 1'b0, 8'b1, 1, 8'b1, 1, 0, 8'h50, 16'h0007);
        repeat (20) step();
        chk_eq("leftover_expectations",
               q_pre.size() + q_st.size() + q_done.size() + q_w_cyc.size() + q_if_cyc.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
